// File: rtl/lab62_soc_pio_edge_in.sv
// Avalon-MM input PIO: synchronises board inputs, optionally debounces them,
// captures edges and raises a maskable level interrupt to the NIOS II.
// Latency: in_port stable before edge t reads back on address 0 after edge t+2+DEBOUNCE.
// Backpressure: none; the slave never stalls, and reads are registered every clock.
//
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   address, chipselect  register select and slave select
//   write_n, writedata   active-low write strobe and write data
//   readdata             registered read data (0 filtered, 1 zero, 2 irqmask, 3 edgecapture)
//   in_port              asynchronous board inputs
//   irq                  level interrupt, |(edgecapture & irqmask)
module lab62_soc_pio_edge_in #(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = 0,
  parameter int BIT_CLEAR = 1,
  parameter int DEBOUNCE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic             wr_en;

  // Only the low WIDTH bits of writedata carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_en = chipselect & ~write_n;

  // Two-flop synchroniser per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  generate
    if (DEBOUNCE == 0) begin : g_no_debounce
      assign filtered = s2;
    end else begin : g_debounce
      localparam int            CW   = $clog2(DEBOUNCE + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

      logic [CW-1:0]    cnt [WIDTH];
      logic [WIDTH-1:0] filt_q;

      // A bit must disagree with the filtered value for DEBOUNCE consecutive
      // cycles before it is accepted; any agreement restarts the count.
      always_ff @(posedge clk) begin
        if (reset) begin
          filt_q <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] != filt_q[i]) begin
              if (cnt[i] == LAST) begin
                filt_q[i] <= s2[i];
                cnt[i]    <= '0;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end else begin
              cnt[i] <= '0;
            end
          end
        end
      end

      assign filtered = filt_q;
    end
  endgenerate

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      1:       edge_det = ~filtered & prev;
      2:       edge_det = filtered ^ prev;
      default: edge_det = filtered & ~prev;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (wr_en && address == 2'd3) begin
      clr_mask = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    end
  end

  // Clear is applied before the new edges are ORed in, so a simultaneous
  // edge and clear on one bit leaves that bit set.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev        <= '0;
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      prev        <= filtered;
      edgecapture <= (edgecapture & ~clr_mask) | edge_det;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(filtered);
        2'd2:    readdata <= 32'(irqmask);
        2'd3:    readdata <= 32'(edgecapture);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: doc/lab62_soc_pio_edge_in.md
Name: lab62_soc_pio_edge_in

Overview:
- Parametrised Avalon-MM input PIO slave for the lab62 SoC. It replaces fixed 1-bit input ports such as the accumulator/keys readers.
- Adds per-bit input synchronisation, optional debounce, edge capture and a maskable level interrupt to the NIOS II.
- Sits between board pins (switches, keys, status lines) and the Platform Designer interconnect.

Parameters:
- WIDTH, 8, input bits, legal range 1..32.
- EDGE_TYPE, 0, capture mode: 0 = rising, 1 = falling, 2 = any edge.
- BIT_CLEAR, 1, edge-clear mode: 1 = write-1-to-clear per bit; 0 = any write to address 3 clears all bits.
- DEBOUNCE, 0, consecutive stable cycles required before a change is accepted; 0 = bypass.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt request.

Behaviour:
- Reset (synchronous, dominates every other event):
  - synchroniser, filtered, prev, debounce counters, irqmask, edgecapture and readdata all clear to 0; irq = 0.
  - Debounce counts in progress are discarded.
- Synchroniser: two flops per bit (s1, s2), no reset bypass.
- Debounce with DEBOUNCE = 0: filtered = s2 (wire).
- Debounce with DEBOUNCE = N > 0: per-bit counter of width clog2(N+1).
  - If s2 != filtered, the counter increments; when it would reach N, filtered <= s2 and the counter <= 0.
  - If s2 == filtered, the counter <= 0. Any glitch shorter than N cycles is rejected.
- Latency: an in_port value stable before edge t appears on readdata (address 0) after edge t+2+N.
- Edge detect: prev <= filtered every cycle.
  - rise = filtered & ~prev; fall = ~filtered & prev. EDGE_TYPE selects rise, fall or rise|fall.
  - A detected edge sets the corresponding edgecapture bit; the bit stays set until cleared.
- An input already high when reset releases produces a rising edge; this is required behaviour. Software clears edgecapture after init.
- Write strobe = chipselect & ~write_n.
  - address 2: irqmask <= writedata[WIDTH-1:0].
  - address 3, BIT_CLEAR = 1: edgecapture &= ~writedata[WIDTH-1:0].
  - address 3, BIT_CLEAR = 0: edgecapture <= 0.
  - Writes to addresses 0 and 1 are ignored.
- Simultaneous edge and clear on the same bit in the same cycle: set wins, bit stays 1.
- readdata is registered every clock, independent of chipselect, and zero-extended to 32 bits:
  - address 0: filtered.
  - address 1: 0 (no direction register).
  - address 2: irqmask.
  - address 3: edgecapture.
- irq = |(edgecapture & irqmask), combinational from registers. It asserts in the cycle after the capturing edge and deasserts in the cycle after the clear or mask write.
- WIDTH < 32: writedata bits above WIDTH are ignored; readdata bits above WIDTH read 0.

Test Plan:
- Reset then read: WIDTH=8; hold reset 2 cycles, in_port=8'h00 → all four addresses read 0; irq=0.
- Latency: DEBOUNCE=0; in_port 8'h00→8'hA5 before edge t, address=0 → readdata=32'h000000A5 first after edge t+2; edgecapture=8'hA5 (EDGE_TYPE=0); irq stays 0 with irqmask=0.
- Debounce: DEBOUNCE=4, WIDTH=1:
  - 3-cycle high pulse → filtered, edgecapture stay 0.
  - Stable high → readdata=1 after edge t+6, edgecapture[0]=1.
- Interrupt and clear: EDGE_TYPE=1, BIT_CLEAR=1; irqmask=8'h0F; falling edge on bit 2 → irq=1.
  - Write 8'h01 to address 3 → edgecapture unchanged, irq=1.
  - Write 8'h04 → edgecapture=0, irq=0 next cycle.
- Set/clear collision: EDGE_TYPE=2; write 8'hFF to address 3 in the same cycle bit 0 toggles → edgecapture=8'h01.
  - Repeat with BIT_CLEAR=0 → same result.
- Mid-operation reset: pending edgecapture=8'h3C, irq=1, debounce count 2 of 4; assert reset 1 cycle → next cycle everything is 0.
  - With in_port held at 8'h3C, a rising capture of 8'h3C reappears after 2+DEBOUNCE+1 cycles.
